// File: rtl/countdown_phase_tracker.sv
// countdown_phase_tracker
//   Consumer of the alternating countdown stream (SHORT_START..0, LONG_START..0, repeating).
//   Locks onto the phase sequence after a zero followed by a start value. Once locked, it
//   checks every accepted sample against the expected decrement/reload pattern.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   count_in     4-bit count value from the countdown counter
//   count_valid  sample count_in this cycle; when low, all state holds
//   phase        phase of the last accepted sample (0 = short, 1 = long)
//   in_sync      high while locked onto the sequence
//   seg          {g,f,e,d,c,b,a} active-high 7-segment decode of the last sampled value
//   phase_done   one-cycle pulse when a phase's final 0 is accepted
//   seq_error    one-cycle pulse on a mismatch while locked
//   err_count    saturating mismatch count
//   cycle_count  wrapping count of completed phases
module countdown_phase_tracker #(
   parameter logic [3:0]  SHORT_START = 4'd5,
   parameter logic [3:0]  LONG_START  = 4'd9,
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned CYC_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       count_in,
   input  logic             count_valid,
   output logic             phase,
   output logic             in_sync,
   output logic [6:0]       seg,
   output logic             phase_done,
   output logic             seq_error,
   output logic [ERR_W-1:0] err_count,
   output logic [CYC_W-1:0] cycle_count
);

   typedef enum logic [1:0] {StHunt, StTrackShort, StTrackLong} state_e;

   localparam logic [ERR_W-1:0] ErrOne = 1;
   localparam logic [CYC_W-1:0] CycOne = 1;

   state_e     state_q;
   logic [3:0] exp_q;
   logic       last_zero_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1111001; // "E" for 10-15
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StHunt;
         exp_q       <= 4'd0;
         last_zero_q <= 1'b1; // lets the counter's post-reset start value lock at once
         phase       <= 1'b0;
         in_sync     <= 1'b0;
         seg         <= 7'b0000000;
         phase_done  <= 1'b0;
         seq_error   <= 1'b0;
         err_count   <= '0;
         cycle_count <= '0;
      end else begin
         phase_done <= 1'b0;
         seq_error  <= 1'b0;
         if (count_valid) begin
            last_zero_q <= (count_in == 4'd0);
            seg         <= seg_decode(count_in);
            unique case (state_q)
               StHunt: begin
                  // A start value only counts as a phase start right after a zero.
                  if (last_zero_q && count_in == SHORT_START) begin
                     state_q <= StTrackShort;
                     in_sync <= 1'b1;
                     exp_q   <= SHORT_START - 4'd1;
                     phase   <= 1'b0;
                  end else if (last_zero_q && count_in == LONG_START) begin
                     state_q <= StTrackLong;
                     in_sync <= 1'b1;
                     exp_q   <= LONG_START - 4'd1;
                     phase   <= 1'b1;
                  end
               end
               StTrackShort, StTrackLong: begin
                  if (count_in != exp_q) begin
                     seq_error <= 1'b1;
                     if (err_count != '1) err_count <= err_count + ErrOne;
                     state_q <= StHunt;
                     in_sync <= 1'b0;
                  end else if (exp_q == 4'd0) begin
                     // Phase complete; phase output flips only once the reload value arrives.
                     phase_done  <= 1'b1;
                     cycle_count <= cycle_count + CycOne;
                     if (state_q == StTrackShort) begin
                        state_q <= StTrackLong;
                        exp_q   <= LONG_START;
                     end else begin
                        state_q <= StTrackShort;
                        exp_q   <= SHORT_START;
                     end
                  end else begin
                     exp_q <= exp_q - 4'd1;
                     phase <= (state_q == StTrackLong);
                  end
               end
               default: begin
                  state_q <= StHunt;
                  in_sync <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
